// File: rtl/count_seq_pkg.sv
// count_seq_pkg
// Shared definitions for the count sequencer: FSM state encodings exposed on
// the state output, and default widths for the prescaler compare value and the
// shadow count / limit.
package count_seq_pkg;

    // Encodings are visible on the state port, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_STEP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DIV_W_DEF = 25;
    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/tick_gen.sv
// tick_gen
// Prescaler for the count sequencer. While en is high the internal pre_cnt
// advances once per cycle; when it reaches (or already exceeds) div_val it
// wraps to 0 and tick is raised for that cycle. Dropping en freezes pre_cnt.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (pre_cnt -> 0)
//   en       in   count enable (high while the controller is running)
//   clr      in   synchronous clear of pre_cnt; also suppresses tick
//   div_val  in   terminal value, one tick per div_val+1 enabled cycles
//   tick     out  combinational terminal-count indication
module tick_gen
    import count_seq_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div_val,
    output logic             tick
);

    logic [DIV_W-1:0] pre_cnt;
    logic             at_term;

    // Greater-or-equal rather than equality: if div_val is lowered below the
    // current count, the next compare still terminates instead of running on
    // through the whole counter range.
    assign at_term = (pre_cnt >= div_val);
    assign tick    = en && at_term && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= at_term ? '0 : pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl
// Run/pause/step/clear sequencer for an external counter datapath. A prescaler
// (tick_gen) paces advances in RUN; a shadow count tracks how many advances
// have been issued so the terminal one can be flagged with done.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   run request
//   pause    in   hold request
//   step     in   single-advance request
//   clr      in   synchronous clear request (highest priority)
//   div_val  in   prescaler terminal, one tick per div_val+1 RUN cycles
//   limit    in   terminal shadow count
//   cnt_en   out  registered one-cycle advance enable
//   cnt_clr  out  registered one-cycle clear
//   done     out  registered one-cycle terminal-count pulse (with cnt_en)
//   busy     out  high in RUN or STEP
//   state    out  FSM state (IDLE=0 RUN=1 PAUSE=2 STEP=3 DONE=4)
//
// Build option: define AUTO_RELOAD_EN to make a terminal advance in RUN pulse
// done, wrap the shadow count and keep running instead of entering DONE.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             step,
    input  logic             clr,
    input  logic [DIV_W-1:0] div_val,
    input  logic [CNT_W-1:0] limit,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             done,
    output logic             busy,
    output logic [2:0]       state
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] sh_cnt;
    logic             tick;
    logic             adv;
    logic             term;
    logic             restart;
    logic             pre_en;
    logic             pre_clr;

    assign pre_en  = (state_q == ST_RUN);
    assign pre_clr = clr || restart;
    assign term    = (sh_cnt == limit);

    tick_gen #(
        .DIV_W(DIV_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (pre_en),
        .clr    (pre_clr),
        .div_val(div_val),
        .tick   (tick)
    );

    // Next state. adv marks a cycle whose edge issues an advance (a RUN tick
    // or entry into STEP); done for that advance is judged against the shadow
    // count before it is bumped.
    always_comb begin
        state_d = state_q;
        adv     = 1'b0;
        restart = 1'b0;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (pause) begin
                        state_d = state_q;
                    end else if (start) begin
                        state_d = ST_RUN;
                    end else if (step) begin
                        state_d = ST_STEP;
                        adv     = 1'b1;
                    end
                end
                ST_RUN: begin
                    adv = tick;
`ifdef AUTO_RELOAD_EN
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end
`else
                    // A terminal tick wins over a simultaneous pause.
                    if (tick && term) begin
                        state_d = ST_DONE;
                    end else if (pause) begin
                        state_d = ST_PAUSE;
                    end
`endif
                end
                ST_STEP: begin
                    // done is the registered terminal flag of this step's advance.
                    state_d = done ? ST_DONE : ST_PAUSE;
                end
                ST_DONE: begin
                    if (!pause && start) begin
                        state_d = ST_RUN;
                        restart = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_cnt  <= '0;
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_en  <= adv;
            cnt_clr <= clr;
            done    <= adv && term;
            if (clr || restart) begin
                sh_cnt <= '0;
            end else if (adv) begin
                sh_cnt <= term ? '0 : sh_cnt + 1'b1;
            end
        end
    end

    assign busy  = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign state = state_q;

endmodule
